// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage:
// state encoding, datapath widths and address stepping.
package fetch_unit_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] a);
        return a + XLEN'(INSTR_BYTES);
    endfunction

    function automatic logic is_aligned(input logic [XLEN-1:0] a);
        return a[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: drives program memory address, pairs returned
// words with their PC, handles replay, redirects and faults.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] pc_out,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            fault,
    output logic [XLEN-1:0] fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_q, fetch_d;
    logic [XLEN-1:0] resp_q, resp_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] count_q;
    logic            rd_ok, rd_bad;

    assign rd_ok  = redirect && is_aligned(redirect_pc);
    assign rd_bad = redirect && !is_aligned(redirect_pc);

    always_comb begin
        state_d     = state_q;
        fetch_d     = fetch_q;
        resp_d      = resp_q;
        fault_d     = fault_q;
        pc_out      = fetch_q;
        instr_valid = 1'b0;
        unique case (state_q)
            BOOT, RUN: begin
                instr_valid = (state_q == RUN) && !redirect;
                if (rd_bad) begin
                    fault_d = 1'b1;
                    state_d = HALT;
                end else if (rd_ok) begin
                    pc_out  = redirect_pc;
                    resp_d  = redirect_pc;
                    fetch_d = next_pc(redirect_pc);
                    state_d = RUN;
                end else if (instr_valid && !instr_ready) begin
                    // replay the word decode has not taken yet
                    pc_out = resp_q;
                end else begin
                    resp_d  = fetch_q;
                    fetch_d = next_pc(fetch_q);
                    state_d = RUN;
                end
            end
            HALT: ;
            default: state_d = HALT;
        endcase
        if (!rst_n) begin
            pc_out      = RESET_PC;
            instr_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            fetch_q <= RESET_PC;
            resp_q  <= RESET_PC;
            fault_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_d;
            resp_q  <= resp_d;
            fault_q <= fault_d;
            if (instr_valid && instr_ready)
                count_q <= count_q + 1'b1;
        end
    end

    assign instr_out   = instr_in;
    assign instr_pc    = resp_q;
    assign fault       = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a stream-level model
// of the fetch rules, plus directed scenarios and a wrap check.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_out, instr_in, instr_out, instr_pc;
    logic        instr_valid, instr_ready, redirect, fault;
    logic [31:0] redirect_pc, fetch_count;

    logic [31:0] pc_out2, instr_in2, instr_out2, instr_pc2, fetch_count2;
    logic        instr_valid2, fault2;
    logic        ready2, redirect2;
    logic [31:0] redirect_pc2;

    int nvec;
    int nerr;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .instr_in(instr_in),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .fault(fault), .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out2), .instr_in(instr_in2),
        .instr_out(instr_out2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .instr_ready(ready2),
        .redirect(redirect2), .redirect_pc(redirect_pc2),
        .fault(fault2), .fetch_count(fetch_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h7ff0_0113;
            32'h0000_0004: return 32'h00c0_00ef;
            32'h0000_0008: return 32'h0000_17b7;
            32'h0000_001C: return 32'h0000_0513;
            32'h0000_0020: return 32'h0000_8067;
            default:       return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
        endcase
    endfunction

    // program memory: one-cycle registered read
    always @(posedge clk) begin
        instr_in  <= memfn(pc_out);
        instr_in2 <= memfn(pc_out2);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
        end
    endtask

    // model: word currently presented (m_cur), next new address (m_next)
    logic        m_boot, m_halt, m_fault;
    logic [31:0] m_cur, m_next, m_count;

    task automatic model_reset();
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_fault = 1'b0;
        m_cur   = 32'h0;
        m_next  = 32'h0;
        m_count = 32'h0;
    endtask

    task automatic step(input logic rn, input logic rdy, input logic rd,
                        input logic [31:0] rpc);
        logic        ev;
        logic [31:0] epc;
        logic        al;
        @(negedge clk);
        rst_n       = rn;
        instr_ready = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        #1;
        al = (rpc[1:0] == 2'b00);
        ev = rn && !m_halt && !m_boot && !rd;
        if (!rn)
            epc = 32'h0;
        else if (m_halt)
            epc = m_next;
        else if (rd)
            epc = al ? rpc : m_next;
        else if (!m_boot && !rdy)
            epc = m_cur;
        else
            epc = m_next;
        check("valid", 32'(instr_valid), 32'(ev));
        check("pc_out", pc_out, epc);
        check("fault", 32'(fault), 32'(m_fault));
        check("count", fetch_count, m_count);
        if (ev) begin
            check("instr_pc", instr_pc, m_cur);
            check("instr_out", instr_out, memfn(m_cur));
        end
        if (!rn) begin
            model_reset();
        end else if (m_halt) begin
        end else if (rd && !al) begin
            m_halt  = 1'b1;
            m_fault = 1'b1;
        end else if (rd) begin
            m_cur  = rpc;
            m_next = rpc + 32'd4;
            m_boot = 1'b0;
        end else if (m_boot) begin
            m_cur  = m_next;
            m_next = m_next + 32'd4;
            m_boot = 1'b0;
        end else if (rdy) begin
            m_count = m_count + 32'd1;
            m_cur   = m_next;
            m_next  = m_next + 32'd4;
        end
    endtask

    initial begin
        logic rn, rdy, rd;
        logic [31:0] rpc;
        nvec         = 0;
        nerr         = 0;
        rst_n        = 1'b0;
        instr_ready  = 1'b1;
        redirect     = 1'b0;
        redirect_pc  = 32'h0;
        ready2       = 1'b1;
        redirect2    = 1'b0;
        redirect_pc2 = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);

        // free run from reset; wrap check on the second instance
        step(1, 1, 0, 0);
        check("w_boot_pc", pc_out2, 32'hFFFF_FFF8);
        check("w_boot_v", 32'(instr_valid2), 32'd0);
        step(1, 1, 0, 0);
        check("w_pc0", instr_pc2, 32'hFFFF_FFF8);
        check("w_v0", 32'(instr_valid2), 32'd1);
        step(1, 1, 0, 0);
        check("w_pc1", instr_pc2, 32'hFFFF_FFFC);
        step(1, 1, 0, 0);
        check("w_pc2", instr_pc2, 32'h0000_0000);
        check("w_out2", instr_out2, 32'h7ff0_0113);
        step(1, 1, 0, 0);
        check("count3", fetch_count, 32'd3);

        // stall on pc 4, release, then redirect to 0x1C while pc 8 shown
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) begin
            step(1, 0, 0, 0);
            check("stall_pc", instr_pc, 32'h4);
        end
        step(1, 1, 0, 0);
        step(1, 1, 1, 32'h1C);
        step(1, 1, 0, 0);
        check("rd_pc", instr_pc, 32'h1C);
        check("rd_out", instr_out, 32'h0000_0513);
        step(1, 1, 0, 0);
        check("rd_out2", instr_out, 32'h0000_8067);

        // redirect together with back-pressure
        step(1, 0, 1, 32'h40);
        step(1, 0, 0, 0);
        check("rdst_pc", instr_pc, 32'h40);
        step(1, 1, 0, 0);

        // misaligned redirect, ignored aligned redirect, reset recovery
        step(1, 1, 1, 32'h1E);
        repeat (3) step(1, 1, 0, 0);
        check("halt_fault", 32'(fault), 32'd1);
        step(1, 1, 1, 32'h100);
        repeat (2) step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        check("restart_pc", instr_pc, 32'h0);

        // randomized traffic
        repeat (4000) begin
            rn  = ($urandom_range(0, 149) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 9) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 39) == 0)
                rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 3) == 0)
                rpc = rpc & 32'h0000_00FC;
            step(rn, rdy, rd, rpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
